// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM access unit.
// State encoding, default widths and the address range check.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    // True when every bit above the RAM word address is zero.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input int unsigned aw
    );
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store initiator for one port of the 16-bit dual-port data RAM.
// Hides the registered read latency and the bank output mux.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t state;

    assign req_ready = (state == S_IDLE) && !reset;
    assign mem_we    = (state == S_WRITE) && !reset;

    // mem_addr doubles as the latched request address; it must stay
    // put through RD_DATA because the RAM output mux follows its MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rsp_rdata <= '0;
                        if (!addr_in_range(32'(req_addr), ADDR_WIDTH)) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            rsp_err  <= 1'b0;
                            mem_addr <= req_addr[ADDR_WIDTH-1:0];
                            if (req_we) begin
                                mem_data <= req_wdata;
                                state    <= S_WRITE;
                            end else begin
                                state <= S_RD_ADDR;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RD_ADDR: begin
                    state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    rsp_rdata <= mem_q;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: banked RAM model, transaction-level
// reference model with a per-cycle compare, plus directed checks.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic [15:0] mem_q;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    // Two-bank RAM: each bank registers its read, output picked by
    // the current address MSB.
    logic [15:0] ram [0:1023];
    logic [15:0] b0_q = '0;
    logic [15:0] b1_q = '0;

    initial for (int i = 0; i < 1024; i++) ram[i] = '0;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        b0_q <= ram[{1'b0, mem_addr[8:0]}];
        b1_q <= ram[{1'b1, mem_addr[8:0]}];
    end

    assign mem_q = mem_addr[9] ? b1_q : b0_q;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endfunction

    // Transaction model: one outstanding request, response appears
    // 0/1/2 edges after acceptance for error/store/load.
    logic [15:0] ref_mem [0:1023];
    int          edge_n = 0;
    bit          started = 0;
    bit          m_have = 0, m_resp = 0, m_store = 0, m_err = 0;
    int          m_acc = 0, m_rdy = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    initial for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    always @(posedge clk) begin
        bit acc;
        edge_n++;
        started = 1;
        if (reset) begin
            m_have = 0;
            m_resp = 0;
        end else begin
            acc = req_valid && !m_have;
            if (m_have && m_store && !m_err && edge_n == m_acc + 1)
                ref_mem[m_addr[9:0]] = m_wdata;
            if (m_resp && rsp_ready) begin
                m_resp = 0;
                m_have = 0;
            end else if (m_have && !m_resp && edge_n == m_rdy) begin
                m_resp = 1;
            end
            if (acc) begin
                m_have  = 1;
                m_acc   = edge_n;
                m_store = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_err   = req_addr >= 16'h0400;
                m_rdata = (m_err || req_we) ? 16'h0 : ref_mem[req_addr[9:0]];
                m_rdy   = edge_n + (m_err ? 0 : (req_we ? 1 : 2));
                m_resp  = m_err;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", 32'(req_ready), 32'(!m_have && !reset));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("mem_we", 32'(mem_we),
                32'(m_have && m_store && !m_err &&
                    edge_n == m_acc && !reset));
            if (m_resp) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from idle; returns response, latency in edges
    // counted from the accept edge, and the accept edge number.
    task automatic xfer(input logic we, input logic [15:0] a,
                        input logic [15:0] d, input int hold,
                        output logic [15:0] rd, output logic er,
                        output int lat, output int acc_e);
        chk("idle_ready", 32'(req_ready), 32'd1);
        if (hold > 0) rsp_ready = 1'b0;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        acc_e = edge_n;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we = 1'b1;
            req_addr = a;
            req_wdata = 16'h0000;
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", 32'(rsp_rdata), 32'(rd));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat, acc_e, prev_e;
    bit          prev_we;

    logic        op_we [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    logic [15:0] op_a  [8] = '{16'h0100, 16'h0300, 16'h0100, 16'h0300,
                               16'h0100, 16'h0100, 16'h01FF, 16'h0200};
    logic [15:0] op_d  [8] = '{16'h1001, 16'h3003, 16'h0, 16'h0,
                               16'hCAFE, 16'h0, 16'h0, 16'h0};
    logic [15:0] op_x  [8] = '{16'h0, 16'h0, 16'h1001, 16'h3003,
                               16'h0, 16'hCAFE, 16'h1234, 16'h5678};

    initial begin
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        tick();

        xfer(1, 16'h0005, 16'hBEEF, 0, rd, er, lat, acc_e);
        chk("st_lat", 32'(lat), 32'd2);
        xfer(0, 16'h0005, 16'h0, 0, rd, er, lat, acc_e);
        chk("ld_5", 32'(rd), 32'hBEEF);
        chk("ld_5_err", 32'(er), 32'd0);
        chk("ld_lat", 32'(lat), 32'd3);

        xfer(1, 16'h01FF, 16'h1234, 0, rd, er, lat, acc_e);
        xfer(1, 16'h0200, 16'h5678, 0, rd, er, lat, acc_e);
        xfer(0, 16'h01FF, 16'h0, 0, rd, er, lat, acc_e);
        chk("ld_1ff", 32'(rd), 32'h1234);
        xfer(0, 16'h0200, 16'h0, 0, rd, er, lat, acc_e);
        chk("ld_200", 32'(rd), 32'h5678);

        xfer(0, 16'h0400, 16'h0, 0, rd, er, lat, acc_e);
        chk("err_ld", 32'(er), 32'd1);
        chk("err_ld_data", 32'(rd), 32'd0);
        chk("err_lat", 32'(lat), 32'd1);
        xfer(1, 16'hFFFF, 16'hFFFF, 0, rd, er, lat, acc_e);
        chk("err_st", 32'(er), 32'd1);
        xfer(0, 16'h03FF, 16'h0, 0, rd, er, lat, acc_e);
        chk("ld_3ff", 32'(rd), 32'h0000);
        chk("ld_3ff_err", 32'(er), 32'd0);

        xfer(0, 16'h0005, 16'h0, 5, rd, er, lat, acc_e);
        chk("hold_data", 32'(rd), 32'hBEEF);
        xfer(0, 16'h0005, 16'h0, 0, rd, er, lat, acc_e);
        chk("hold_no_write", 32'(rd), 32'hBEEF);

        xfer(1, 16'h0010, 16'h1111, 0, rd, er, lat, acc_e);
        req_we = 1'b1;
        req_addr = 16'h0010;
        req_wdata = 16'hAAAA;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("write_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_write_we", 32'(mem_we), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        xfer(0, 16'h0010, 16'h0, 0, rd, er, lat, acc_e);
        chk("rst_keep_old", 32'(rd), 32'h1111);

        prev_e = 0;
        prev_we = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(op_we[i], op_a[i], op_d[i], 0, rd, er, lat, acc_e);
            if (i > 0)
                chk($sformatf("b2b_gap%0d", i), 32'(acc_e - prev_e),
                    prev_we ? 32'd3 : 32'd4);
            if (!op_we[i])
                chk($sformatf("b2b_data%0d", i), 32'(rd), 32'(op_x[i]));
            prev_e = acc_e;
            prev_we = op_we[i];
        end

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
